mem_port_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the CPU instruction-fetch requester and the data-access requester.
- Each transaction is sequenced through a 4-state FSM: address handshake, data handshake, then a one-cycle response.
- Generates a CPU stall while any request is outstanding.
- Sits between the CPU core's fetch/memory stages and the cache/AXI bridge; replaces the separate inst/data SRAM ports with a single arbitrated port.

---
 rtl/cpu_defs.sv | 14 +
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the memory-port arbiter: FSM state and grant encodings.
package cpu_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates CPU fetch and data requests onto one SRAM-like port, one transaction at a time.
//
// state | meaning
// IDLE  | arbitrate, data has fixed priority; latch the granted request
// ADDR  | mem_req held high with latched fields until mem_addr_ok
// DATA  | wait for mem_data_ok, capture read data for the granted side
// RESP  | one-cycle ready pulse to the granted side (unless fetch was flushed)
module mem_port_arbiter
  import cpu_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ready,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  state_t state;
  logic   gnt;
  logic   discard;

  assign cpu_stall = (inst_req & ~inst_ready) | (data_req & ~data_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= GNT_INST;
      discard    <= 1'b0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wstrb  <= 4'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          discard <= 1'b0;
          if (data_req) begin
            gnt       <= GNT_DATA;
            mem_addr  <= data_addr;
            mem_wr    <= data_wr;
            mem_wstrb <= data_wstrb;
            mem_wdata <= data_wdata;
            mem_req   <= 1'b1;
            state     <= ADDR;
          end else if (inst_req) begin
            gnt       <= GNT_INST;
            mem_addr  <= inst_addr;
            mem_wr    <= 1'b0;
            mem_wstrb <= 4'b0;
            mem_wdata <= '0;
            mem_req   <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (mem_data_ok) begin
            state <= RESP;
            if (gnt == GNT_DATA) begin
              data_rdata <= mem_rdata;
              data_ready <= 1'b1;
            // a flush arriving together with data_ok must already discard
            end else if (!(discard || flush)) begin
              inst_rdata <= mem_rdata;
              inst_ready <= 1'b1;
            end
          end
        end
        RESP: state <= IDLE;
      endcase
      if (state != IDLE && gnt == GNT_INST && flush)
        discard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a hand-driven memory side.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        flush;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        cpu_stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ready(data_ready),
    .flush(flush),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // inputs change 1ns after the rising edge; checks happen 2ns later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
    data_addr = 0; data_wdata = 0; flush = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    cyc(); cyc();
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_readys", {inst_ready, data_ready}, 0);
    chk("rst_rdatas", inst_rdata | data_rdata, 0);
    cyc(); rst = 0;

    // single load
    cyc(); data_req = 1; data_wr = 0; data_addr = 32'h0000_1000;
    #2; chk("ld_c0_stall", cpu_stall, 1); chk("ld_c0_mreq", mem_req, 0);
    cyc(); mem_addr_ok = 1;
    #2; chk("ld_c1_mreq", mem_req, 1); chk("ld_c1_addr", mem_addr, 32'h0000_1000);
    chk("ld_c1_wr", mem_wr, 0); chk("ld_c1_stall", cpu_stall, 1);
    cyc(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
    #2; chk("ld_c2_mreq", mem_req, 0); chk("ld_c2_rdy", data_ready, 0); chk("ld_c2_stall", cpu_stall, 1);
    cyc(); mem_data_ok = 0; mem_rdata = 0;
    #2; chk("ld_c3_rdy", data_ready, 1); chk("ld_c3_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("ld_c3_stall", cpu_stall, 0);
    cyc(); data_req = 0;
    #2; chk("ld_c4_rdy", data_ready, 0); chk("ld_c4_mreq", mem_req, 0);
    cyc();

    // collision: store wins, fetch follows after one idle cycle
    cyc(); inst_req = 1; inst_addr = 32'hBFC0_0000;
    data_req = 1; data_wr = 1; data_addr = 32'h0000_2000; data_wdata = 32'h1234_5678; data_wstrb = 4'b0011;
    cyc(); mem_addr_ok = 1;
    #2; chk("col_d_mreq", mem_req, 1); chk("col_d_addr", mem_addr, 32'h0000_2000);
    chk("col_d_wr", mem_wr, 1); chk("col_d_wstrb", mem_wstrb, 4'b0011); chk("col_d_wdata", mem_wdata, 32'h1234_5678);
    cyc(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA_5555;
    cyc(); mem_data_ok = 0;
    #2; chk("col_d_rdy", {inst_ready, data_ready}, 2'b01); chk("col_d_rdata", data_rdata, 32'hAAAA_5555);
    cyc(); data_req = 0; data_wr = 0;
    #2; chk("col_idle_mreq", mem_req, 0);
    cyc(); mem_addr_ok = 1;
    #2; chk("col_i_mreq", mem_req, 1); chk("col_i_addr", mem_addr, 32'hBFC0_0000);
    chk("col_i_wr", mem_wr, 0); chk("col_i_wstrb", mem_wstrb, 0);
    cyc(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h3C08_0001;
    cyc(); mem_data_ok = 0;
    #2; chk("col_i_rdy", {inst_ready, data_ready}, 2'b10); chk("col_i_rdata", inst_rdata, 32'h3C08_0001);
    cyc(); inst_req = 0;
    cyc();

    // backpressure with moving inst_addr
    cyc(); inst_req = 1; inst_addr = 32'h0000_0100;
    for (int i = 1; i <= 5; i++) begin
      cyc(); inst_addr = 32'h0000_0100 + 32'(4 * i);
      #2; chk("bp_mreq", mem_req, 1); chk("bp_addr", mem_addr, 32'h0000_0100);
    end
    cyc(); mem_addr_ok = 1;
    #2; chk("bp_last_addr", mem_addr, 32'h0000_0100);
    cyc(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1111_2222;
    #2; chk("bp_data_mreq", mem_req, 0);
    cyc(); mem_data_ok = 0;
    #2; chk("bp_rdy", inst_ready, 1); chk("bp_rdata", inst_rdata, 32'h1111_2222);
    cyc(); inst_req = 0;
    cyc();

    // flush during fetch DATA state
    cyc(); inst_req = 1; inst_addr = 32'h0000_0200;
    cyc(); mem_addr_ok = 1;
    cyc(); mem_addr_ok = 0; flush = 1;
    cyc(); flush = 0; inst_req = 0; mem_data_ok = 1; mem_rdata = 32'h0800_0000;
    cyc(); mem_data_ok = 0;
    #2; chk("fl_resp_rdy", inst_ready, 0); chk("fl_rdata", inst_rdata, 32'h1111_2222);
    cyc();
    #2; chk("fl_idle_rdy", inst_ready, 0); chk("fl_idle_mreq", mem_req, 0);
    cyc();

    // back-to-back fetch with inst_req held
    cyc(); inst_req = 1; inst_addr = 32'h0000_0400;
    cyc(); mem_addr_ok = 1;
    cyc(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0000_000A;
    cyc(); mem_data_ok = 0; inst_addr = 32'h0000_0404;
    #2; chk("b2b_rdy1", inst_ready, 1); chk("b2b_rdata1", inst_rdata, 32'h0000_000A);
    chk("b2b_resp_mreq", mem_req, 0);
    cyc();
    #2; chk("b2b_idle_mreq", mem_req, 0); chk("b2b_idle_rdy", inst_ready, 0);
    cyc(); mem_addr_ok = 1;
    #2; chk("b2b_mreq2", mem_req, 1); chk("b2b_addr2", mem_addr, 32'h0000_0404);
    cyc(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0000_000B;
    cyc(); mem_data_ok = 0;
    #2; chk("b2b_rdy2", inst_ready, 1); chk("b2b_rdata2", inst_rdata, 32'h0000_000B);
    cyc(); inst_req = 0;
    cyc();

    // reset in DATA state
    cyc(); data_req = 1; data_wr = 0; data_addr = 32'h0000_3000;
    cyc(); mem_addr_ok = 1;
    cyc(); mem_addr_ok = 0; rst = 1; data_req = 0;
    cyc(); rst = 0; mem_data_ok = 1; mem_rdata = 32'hFFFF_FFFF;
    #2; chk("rm_mreq", mem_req, 0); chk("rm_rdys", {inst_ready, data_ready}, 0);
    chk("rm_irdata", inst_rdata, 0); chk("rm_drdata", data_rdata, 0);
    cyc(); mem_data_ok = 0;
    #2; chk("rm_late_rdy", data_ready, 0); chk("rm_late_rdata", data_rdata, 0);
    chk("rm_late_mreq", mem_req, 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
